route_sequencer: RTL and testbench

ROUTE_SEQUENCER -- requirements
Module: route_sequencer

---
 rtl/route_sequencer.sv | 155 +++++++++++++++
 tb/tb_route_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/route_sequencer.sv
// rtl/route_sequencer.sv - junction-driven route playback sequencer
// Steps through a programmed move list, one move per debounced junction.
module route_sequencer #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 150_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       progWe,
  input  logic [3:0] progAddr,
  input  logic [2:0] progData,
  input  logic [4:0] routeLen,
  input  logic       start,
  input  logic       abort,
  input  logic       jncDetect,
  input  logic       jncDone,
  input  logic       colDetect,
  output logic [2:0] tdDir,
  output logic       moveValid,
  output logic [3:0] routeIdx,
  output logic       busy,
  output logic       routeDone,
  output logic       fault
);

  // Timer width follows TIMEOUT so the default cycle count is representable.
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_JNC, S_WAIT_DONE, S_DONE, S_FAULT} state_t;

  state_t        r_state, w_nxt_state;
  logic [2:0]    r_mem [16];
  logic [7:0]    r_deb, w_nxt_deb;
  logic [TW-1:0] r_tmr, w_nxt_tmr;
  logic [4:0]    r_len, w_nxt_len;
  logic [3:0]    r_idx, w_nxt_idx;
  logic [2:0]    r_td, w_nxt_td;
  logic          r_mv, w_nxt_mv;
  logic          r_busy, r_done, r_fault;

  logic [2:0] w_code;
  logic       w_qual, w_deb_hit, w_last, w_tmo, w_code_ok, w_len_ok;

  assign w_code    = r_mem[r_idx];
  assign w_qual    = jncDetect & colDetect;
  assign w_deb_hit = w_qual && (r_deb == 8'(DEBOUNCE - 1));
  assign w_last    = ({1'b0, r_idx} == (r_len - 5'd1));
  assign w_tmo     = colDetect && (r_tmr == TW'(TIMEOUT - 1));
  assign w_code_ok = (w_code != 3'd0) && (w_code <= 3'd4);
  assign w_len_ok  = (routeLen != 5'd0) && (routeLen <= 5'd16);

  // Route memory keeps its contents across reset so a route can be replayed.
  always_ff @(posedge clk) begin
    if (progWe && r_state == S_IDLE)
      r_mem[progAddr] <= progData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_deb   <= '0;
      r_tmr   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_td    <= '0;
      r_mv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_deb   <= w_nxt_deb;
      r_tmr   <= w_nxt_tmr;
      r_len   <= w_nxt_len;
      r_idx   <= w_nxt_idx;
      r_td    <= w_nxt_td;
      r_mv    <= w_nxt_mv;
      r_busy  <= (w_nxt_state == S_WAIT_JNC) || (w_nxt_state == S_WAIT_DONE);
      r_done  <= (w_nxt_state == S_DONE);
      r_fault <= (w_nxt_state == S_FAULT);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:
        if (start) w_nxt_state = w_len_ok ? S_WAIT_JNC : S_DONE;
      S_WAIT_JNC:
        if (w_deb_hit) begin
          if (w_code_ok)           w_nxt_state = S_WAIT_DONE;
          else if (w_code == 3'd0) w_nxt_state = S_DONE;
          else                     w_nxt_state = S_FAULT;
        end
      S_WAIT_DONE:
        if (jncDone)    w_nxt_state = w_last ? S_DONE : S_WAIT_JNC;
        else if (w_tmo) w_nxt_state = S_FAULT;
      default: w_nxt_state = r_state;
    endcase
    if (abort) w_nxt_state = S_IDLE;
  end

  always_comb begin
    w_nxt_deb = r_deb;
    w_nxt_tmr = r_tmr;
    w_nxt_len = r_len;
    w_nxt_idx = r_idx;
    w_nxt_td  = r_td;
    w_nxt_mv  = 1'b0;
    case (r_state)
      S_IDLE:
        if (start) begin
          w_nxt_len = routeLen;
          w_nxt_idx = '0;
          w_nxt_deb = '0;
          w_nxt_td  = '0;
        end
      S_WAIT_JNC: begin
        w_nxt_deb = w_qual ? r_deb + 8'd1 : 8'd0;
        if (w_deb_hit) begin
          w_nxt_deb = '0;
          w_nxt_tmr = '0;
          w_nxt_td  = w_code_ok ? w_code : 3'd0;
          w_nxt_mv  = w_code_ok;
        end
      end
      S_WAIT_DONE: begin
        if (colDetect) w_nxt_tmr = r_tmr + TW'(1);
        if (jncDone) begin
          w_nxt_td  = '0;
          w_nxt_deb = '0;
          if (!w_last) w_nxt_idx = r_idx + 4'd1;
        end else if (w_tmo) begin
          w_nxt_td = '0;
        end
      end
      default: ;
    endcase
    if (abort) begin
      w_nxt_td  = '0;
      w_nxt_idx = '0;
      w_nxt_deb = '0;
      w_nxt_tmr = '0;
      w_nxt_mv  = 1'b0;
    end
  end

  assign tdDir     = r_td;
  assign moveValid = r_mv;
  assign routeIdx  = r_idx;
  assign busy      = r_busy;
  assign routeDone = r_done;
  assign fault     = r_fault;

endmodule

// File: tb/tb_route_sequencer.sv
// tb/tb_route_sequencer.sv - directed-vector bench for route_sequencer
module tb_route_sequencer;

  logic       clk = 1'b0;
  logic       rst, progWe, start, abort, jncDetect, jncDone, colDetect;
  logic [3:0] progAddr;
  logic [2:0] progData;
  logic [4:0] routeLen;
  logic [2:0] tdDir;
  logic       moveValid, busy, routeDone, fault;
  logic [3:0] routeIdx;

  int n_vec  = 0;
  int n_mis  = 0;
  int mv_cnt = 0;
  int c0;

  route_sequencer #(.DEBOUNCE(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .progWe(progWe), .progAddr(progAddr), .progData(progData),
    .routeLen(routeLen), .start(start), .abort(abort), .jncDetect(jncDetect),
    .jncDone(jncDone), .colDetect(colDetect), .tdDir(tdDir), .moveValid(moveValid),
    .routeIdx(routeIdx), .busy(busy), .routeDone(routeDone), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (moveValid === 1'b1) mv_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int a, input int d);
    progWe = 1'b1; progAddr = 4'(a); progData = 3'(d);
    tick();
    progWe = 1'b0;
  endtask

  task automatic go(input int len);
    routeLen = 5'(len); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic jnc(input int n);
    jncDetect = 1'b1;
    repeat (n) tick();
    jncDetect = 1'b0;
  endtask

  task automatic finish_move();
    jncDone = 1'b1;
    tick();
    jncDone = 1'b0;
  endtask

  task automatic abort_now();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic run_route(input string tag);
    int exp_code [3];
    exp_code = '{2, 1, 3};
    for (int k = 0; k < 3; k++) begin
      jnc(4);
      chk({tag, "_mv"}, moveValid, 1);
      chk({tag, "_dir"}, tdDir, exp_code[k]);
      tick();
      chk({tag, "_mv_pulse"}, moveValid, 0);
      chk({tag, "_dir_hold"}, tdDir, exp_code[k]);
      finish_move();
      chk({tag, "_dir_clr"}, tdDir, 0);
    end
    chk({tag, "_done"}, routeDone, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; progWe = 1'b0; start = 1'b0; abort = 1'b0;
    jncDetect = 1'b0; jncDone = 1'b0; colDetect = 1'b1;
    progAddr = '0; progData = '0; routeLen = '0;
    tick(); tick();
    chk("rst_dir", tdDir, 0);
    chk("rst_mv", moveValid, 0);
    chk("rst_idx", routeIdx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", routeDone, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    tick();

    // basic three-move route
    prog(0, 2); prog(1, 1); prog(2, 3);
    c0 = mv_cnt;
    go(3);
    chk("start_busy", busy, 1);
    chk("start_idx", routeIdx, 0);
    run_route("route");
    chk("route_mv_count", mv_cnt - c0, 3);
    go(3);
    chk("done_hold", routeDone, 1);
    abort_now();
    chk("abort_idle_done", routeDone, 0);

    // debounce gap and collision reset
    c0 = mv_cnt;
    go(3);
    jnc(3);
    tick();
    jnc(3);
    chk("deb_gap_mv", moveValid, 0);
    jnc(1);
    chk("deb_4th_mv", moveValid, 1);
    chk("deb_4th_dir", tdDir, 2);
    tick();
    chk("deb_one_move", mv_cnt - c0, 1);
    finish_move();
    jncDetect = 1'b1;
    tick(); tick();
    colDetect = 1'b0;
    tick();
    colDetect = 1'b1;
    tick(); tick(); tick();
    chk("col_clear_mv", moveValid, 0);
    tick();
    chk("col_4th_mv", moveValid, 1);
    chk("col_4th_dir", tdDir, 1);
    jncDetect = 1'b0;

    // timeout: 100 cycles in WAIT_DONE
    repeat (99) tick();
    chk("tmo_99", fault, 0);
    tick();
    chk("tmo_100", fault, 1);
    chk("tmo_dir", tdDir, 0);
    chk("tmo_busy", busy, 0);
    abort_now();
    go(3);
    jnc(4);
    colDetect = 1'b0;
    repeat (20) tick();
    colDetect = 1'b1;
    repeat (99) tick();
    chk("tmo_col_119", fault, 0);
    tick();
    chk("tmo_col_120", fault, 1);
    abort_now();

    // invalid code and STOP code
    prog(0, 6);
    c0 = mv_cnt;
    go(3);
    jnc(4);
    chk("bad_fault", fault, 1);
    chk("bad_dir", tdDir, 0);
    tick();
    chk("bad_no_mv", mv_cnt - c0, 0);
    abort_now();
    prog(0, 2); prog(1, 0);
    go(3);
    jnc(4);
    chk("stop_first_dir", tdDir, 2);
    finish_move();
    chk("stop_idx", routeIdx, 1);
    jnc(4);
    chk("stop_done", routeDone, 1);
    chk("stop_dir", tdDir, 0);
    chk("stop_mv", moveValid, 0);
    abort_now();
    prog(1, 1);

    // asynchronous reset mid-route, then replay
    go(3);
    for (int k = 0; k < 2; k++) begin
      jnc(4);
      finish_move();
    end
    jnc(4);
    chk("pre_rst_idx", routeIdx, 2);
    chk("pre_rst_dir", tdDir, 3);
    rst = 1'b1;
    #1;
    chk("arst_dir", tdDir, 0);
    chk("arst_mv", moveValid, 0);
    chk("arst_idx", routeIdx, 0);
    chk("arst_busy", busy, 0);
    rst = 1'b0;
    tick();
    go(3);
    run_route("replay");
    abort_now();

    // abort beats jncDone; writes outside IDLE ignored
    go(3);
    jnc(4);
    abort = 1'b1; jncDone = 1'b1;
    tick();
    abort = 1'b0; jncDone = 1'b0;
    chk("abort_jd_busy", busy, 0);
    chk("abort_jd_done", routeDone, 0);
    chk("abort_jd_dir", tdDir, 0);
    go(3);
    prog(0, 4);
    jnc(4);
    chk("prog_ignored", tdDir, 2);
    abort_now();

    // jncDone outside WAIT_DONE and length boundaries
    go(3);
    finish_move();
    chk("jd_ign_busy", busy, 1);
    chk("jd_ign_idx", routeIdx, 0);
    abort_now();
    go(0);
    chk("len0_done", routeDone, 1);
    abort_now();
    go(17);
    chk("len17_done", routeDone, 1);
    abort_now();
    go(16);
    chk("len16_busy", busy, 1);
    abort_now();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
